// File: rtl/hps_instr_fifo.sv
// hps_instr_fifo
// Takes the HPS instruction and boot-loader-flag PIO words, detects each new
// command from the toggle bit in instruction[10], and buffers the 10-bit
// payload in a first-word-fall-through FIFO.
// Output is held back while the boot loader flag is high.
// Optional feature macro: HPS_INSTR_DROP_CNT_EN adds the drop_count port and
// its 8-bit saturating counter.

module hps_instr_fifo #(
    parameter  int DEPTH = 16,
    localparam int LW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          boot_loader_flag,
    input  logic [10:0]   instruction,
    output logic          cmd_valid,
    input  logic          cmd_ready,
    output logic [1:0]    cmd_opcode,
    output logic [7:0]    cmd_operand,
    output logic [LW-1:0] fifo_level,
    output logic          overflow,
    output logic          loader_mode
`ifdef HPS_INSTR_DROP_CNT_EN
    ,
    output logic [7:0]    drop_count
`endif
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic {
        LOADER = 1'b0,
        RUN    = 1'b1
    } state_t;

    state_t        state;
    state_t        next_state;

    logic [10:0]   instr_q;
    logic          flag_q;
    logic          tog_prev;

    logic [9:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [LW-1:0] level;

    logic          push_req;
    logic          full;
    logic          pop;
    logic          flush;
    logic          push_ok;
    logic          drop;

    // Register the PIO inputs once before they are used.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            instr_q <= 11'd0;
            flag_q  <= 1'b1;
        end else begin
            instr_q <= instruction;
            flag_q  <= boot_loader_flag;
        end
    end

    // State register for the loader/run mode machine.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= LOADER;
        end else begin
            state <= next_state;
        end
    end

    // Next state, handshake and push/pop/flush decisions.
    // A flush outranks any push or pop in the same cycle.
    always_comb begin
        next_state  = state;
        loader_mode = 1'b0;
        cmd_valid   = 1'b0;
        pop         = 1'b0;
        flush       = 1'b0;
        push_req    = (instr_q[10] != tog_prev);
        full        = (level == LW'(DEPTH));
        case (state)
            LOADER: begin
                loader_mode = 1'b1;
                if (!flag_q) begin
                    next_state = RUN;
                end
            end
            RUN: begin
                cmd_valid = (level != '0);
                pop       = cmd_valid && cmd_ready;
                if (flag_q) begin
                    next_state = LOADER;
                    flush      = 1'b1;
                end
            end
            default: begin
                next_state = LOADER;
            end
        endcase
        push_ok = push_req && !flush && (!full || pop);
        drop    = push_req && !flush && full && !pop;
    end

    // Remember the last toggle seen, whether or not its command was kept.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tog_prev <= 1'b0;
        end else if (push_req) begin
            tog_prev <= instr_q[10];
        end
    end

    // Pointers and occupancy; a flush empties the FIFO outright.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (push_ok && !pop) begin
                level <= level + LW'(1);
            end else if (pop && !push_ok) begin
                level <= level - LW'(1);
            end
        end
    end

    // Payload storage, left unreset so it can map onto RAM.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= instr_q[9:0];
        end
    end

    // Sticky overflow flag, cleared when a flush returns to loader mode.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            overflow <= 1'b0;
        end else if (flush) begin
            overflow <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
        end
    end

`ifdef HPS_INSTR_DROP_CNT_EN
    // Saturating count of dropped commands, cleared with the flush.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            drop_count <= 8'd0;
        end else if (flush) begin
            drop_count <= 8'd0;
        end else if (drop && (drop_count != 8'hFF)) begin
            drop_count <= drop_count + 8'd1;
        end
    end
`else
`endif

    // The head word is shown only while valid, so it reads zero otherwise.
    always_comb begin
        cmd_opcode  = 2'd0;
        cmd_operand = 8'd0;
        if (cmd_valid) begin
            {cmd_opcode, cmd_operand} = mem[rd_ptr];
        end
    end

    assign fifo_level = level;

endmodule

// File: tb/tb_hps_instr_fifo.sv
// Testbench for hps_instr_fifo: table-driven single commands plus
// hand-written sequences for loader buffering, full/overflow, flush and reset.

module tb_hps_instr_fifo;

    localparam int DEPTH = 16;
    localparam int LW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          boot_loader_flag;
    logic [10:0]   instruction;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [1:0]    cmd_opcode;
    logic [7:0]    cmd_operand;
    logic [LW-1:0] fifo_level;
    logic          overflow;
    logic          loader_mode;
`ifdef HPS_INSTR_DROP_CNT_EN
    logic [7:0]    drop_count;
`endif

    int checks = 0;
    int errors = 0;
    logic tog;
    logic [9:0] sb [$];

    typedef struct {
        logic [10:0] word;
        logic        exp_valid;
        logic [1:0]  exp_op;
        logic [7:0]  exp_operand;
    } vec_t;

    vec_t vecs [6];

    hps_instr_fifo #(.DEPTH(DEPTH)) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .boot_loader_flag (boot_loader_flag),
        .instruction      (instruction),
        .cmd_valid        (cmd_valid),
        .cmd_ready        (cmd_ready),
        .cmd_opcode       (cmd_opcode),
        .cmd_operand      (cmd_operand),
        .fifo_level       (fifo_level),
        .overflow         (overflow),
        .loader_mode      (loader_mode)
`ifdef HPS_INSTR_DROP_CNT_EN
        ,
        .drop_count       (drop_count)
`endif
    );

    // 100 MHz-style free-running clock; edges at 5, 15, ... and 10, 20, ...
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [10:0] word, input logic flag,
                                 input logic ready);
        instruction      = word;
        boot_loader_flag = flag;
        cmd_ready        = ready;
    endtask

    // Issue one new command by flipping the toggle; takes one clock.
    task automatic sendCmd(input logic [1:0] op, input logic [7:0] operand,
                           input bit store);
        tog         = ~tog;
        instruction = {tog, op, operand};
        if (store) begin
            sb.push_back({op, operand});
        end
        @(negedge clk);
    endtask

    // Compare the presented head against the oldest expected command.
    task automatic headCheck(input string name);
        logic [9:0] exp;
        checkOutput({name, " valid"}, 32'(cmd_valid), 32'd1);
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL %s head actual=%0h required=scoreboard entry (none left)",
                     name, {cmd_opcode, cmd_operand});
        end else begin
            exp = sb.pop_front();
            checkOutput({name, " head"}, 32'({cmd_opcode, cmd_operand}), 32'(exp));
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        vecs[0] = '{11'h4A5, 1'b1, 2'd0, 8'hA5};
        vecs[1] = '{11'h35A, 1'b1, 2'd3, 8'h5A};
        vecs[2] = '{11'h6FF, 1'b1, 2'd2, 8'hFF};
        vecs[3] = '{11'h100, 1'b1, 2'd1, 8'h00};
        vecs[4] = '{11'h7C3, 1'b1, 2'd3, 8'hC3};
        vecs[5] = '{11'h7AA, 1'b0, 2'd0, 8'h00};

        // Reset state
        tog = 1'b0;
        reset_n = 1'b0;
        applyStimulus(11'h000, 1'b1, 1'b0);
        #12;
        checkOutput("reset cmd_valid", 32'(cmd_valid), 32'd0);
        checkOutput("reset opcode", 32'(cmd_opcode), 32'd0);
        checkOutput("reset operand", 32'(cmd_operand), 32'd0);
        checkOutput("reset level", 32'(fifo_level), 32'd0);
        checkOutput("reset overflow", 32'(overflow), 32'd0);
        checkOutput("reset loader_mode", 32'(loader_mode), 32'd1);
`ifdef HPS_INSTR_DROP_CNT_EN
        checkOutput("reset drop_count", 32'(drop_count), 32'd0);
`endif

        // Release and drop the flag: state follows one edge after capture
        @(negedge clk);
        reset_n = 1'b1;
        boot_loader_flag = 1'b0;
        @(negedge clk);
        checkOutput("flag capture loader_mode", 32'(loader_mode), 32'd1);
        @(negedge clk);
        checkOutput("run loader_mode", 32'(loader_mode), 32'd0);

        // Table: single commands in RUN with an empty FIFO
        for (int i = 0; i < 6; i++) begin
            instruction = vecs[i].word;
            tog = instruction[10];
            @(negedge clk);
            checkOutput($sformatf("vec%0d latency valid", i), 32'(cmd_valid), 32'd0);
            @(negedge clk);
            checkOutput($sformatf("vec%0d valid", i), 32'(cmd_valid), 32'(vecs[i].exp_valid));
            checkOutput($sformatf("vec%0d level", i), 32'(fifo_level), 32'(vecs[i].exp_valid));
            if (vecs[i].exp_valid) begin
                checkOutput($sformatf("vec%0d opcode", i), 32'(cmd_opcode), 32'(vecs[i].exp_op));
                checkOutput($sformatf("vec%0d operand", i), 32'(cmd_operand),
                            32'(vecs[i].exp_operand));
            end
            cmd_ready = 1'b1;
            @(negedge clk);
            cmd_ready = 1'b0;
            checkOutput($sformatf("vec%0d level after pop", i), 32'(fifo_level), 32'd0);
            checkOutput($sformatf("vec%0d valid after pop", i), 32'(cmd_valid), 32'd0);
        end

        // Loader mode buffers without presenting, then drains in order
        boot_loader_flag = 1'b1;
        cycles(2);
        checkOutput("loader loader_mode", 32'(loader_mode), 32'd1);
        sendCmd(2'd1, 8'h11, 1'b1);
        sendCmd(2'd2, 8'h22, 1'b1);
        sendCmd(2'd3, 8'h33, 1'b1);
        cycles(1);
        checkOutput("loader level", 32'(fifo_level), 32'd3);
        checkOutput("loader valid withheld", 32'(cmd_valid), 32'd0);
        boot_loader_flag = 1'b0;
        cmd_ready = 1'b1;
        cycles(2);
        for (int i = 0; i < 3; i++) begin
            headCheck($sformatf("drain%0d", i));
            @(negedge clk);
        end
        cmd_ready = 1'b0;
        checkOutput("drain level", 32'(fifo_level), 32'd0);
        checkOutput("drain valid", 32'(cmd_valid), 32'd0);

        // Fill to DEPTH, then push and pop together at full
        for (int i = 0; i < DEPTH; i++) begin
            sendCmd(2'(i), 8'(i * 7 + 3), 1'b1);
        end
        cycles(1);
        checkOutput("fill level", 32'(fifo_level), 32'(DEPTH));
        checkOutput("fill overflow", 32'(overflow), 32'd0);
        sendCmd(2'd1, 8'hEE, 1'b1);
        cmd_ready = 1'b1;
        headCheck("full push+pop");
        @(negedge clk);
        cmd_ready = 1'b0;
        checkOutput("full push+pop level", 32'(fifo_level), 32'(DEPTH));
        checkOutput("full push+pop overflow", 32'(overflow), 32'd0);

        // Two more while full are dropped
        sendCmd(2'd0, 8'hD1, 1'b0);
        sendCmd(2'd0, 8'hD2, 1'b0);
        cycles(1);
        checkOutput("overflow level", 32'(fifo_level), 32'(DEPTH));
        checkOutput("overflow flag", 32'(overflow), 32'd1);
`ifdef HPS_INSTR_DROP_CNT_EN
        checkOutput("overflow drop_count", 32'(drop_count), 32'd2);
`endif

        // Drain 11 in order, leaving 5; overflow is sticky
        cmd_ready = 1'b1;
        for (int i = 0; i < 11; i++) begin
            headCheck($sformatf("ovf drain%0d", i));
            @(negedge clk);
        end
        cmd_ready = 1'b0;
        checkOutput("partial level", 32'(fifo_level), 32'd5);
        checkOutput("partial overflow sticky", 32'(overflow), 32'd1);

        // Raise flag with a coincident push: flush wins
        boot_loader_flag = 1'b1;
        sendCmd(2'd3, 8'h99, 1'b0);
        checkOutput("flush edge k level", 32'(fifo_level), 32'd5);
        checkOutput("flush edge k loader_mode", 32'(loader_mode), 32'd0);
        @(negedge clk);
        checkOutput("flush level", 32'(fifo_level), 32'd0);
        checkOutput("flush overflow", 32'(overflow), 32'd0);
        checkOutput("flush valid", 32'(cmd_valid), 32'd0);
        checkOutput("flush loader_mode", 32'(loader_mode), 32'd1);
`ifdef HPS_INSTR_DROP_CNT_EN
        checkOutput("flush drop_count", 32'(drop_count), 32'd0);
`endif
        sb.delete();
        cycles(1);
        checkOutput("flush push discarded", 32'(fifo_level), 32'd0);

        // Reset in the middle of a drain
        boot_loader_flag = 1'b0;
        cycles(2);
        checkOutput("pre-reset loader_mode", 32'(loader_mode), 32'd0);
        for (int i = 0; i < 4; i++) begin
            sendCmd(2'(i + 1), 8'(8'h40 + i), 1'b1);
        end
        cycles(1);
        checkOutput("pre-reset level", 32'(fifo_level), 32'd4);
        cmd_ready = 1'b1;
        headCheck("pre-reset pop");
        @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        checkOutput("midreset valid", 32'(cmd_valid), 32'd0);
        checkOutput("midreset level", 32'(fifo_level), 32'd0);
        checkOutput("midreset loader_mode", 32'(loader_mode), 32'd1);
        checkOutput("midreset overflow", 32'(overflow), 32'd0);
        checkOutput("midreset opcode", 32'(cmd_opcode), 32'd0);
        checkOutput("midreset operand", 32'(cmd_operand), 32'd0);
        sb.delete();
        tog = 1'b0;
        applyStimulus(11'h000, 1'b1, 1'b0);
        @(negedge clk);
        reset_n = 1'b1;
        boot_loader_flag = 1'b0;
        cycles(2);
        instruction = 11'h0AA;
        cycles(2);
        checkOutput("post-reset toggle0 ignored", 32'(fifo_level), 32'd0);
        sendCmd(2'd2, 8'h3C, 1'b1);
        cycles(1);
        checkOutput("post-reset toggle1 level", 32'(fifo_level), 32'd1);
        headCheck("post-reset first cmd");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Safety net in case the main sequence stalls
    initial begin
        #200000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog");
    end

endmodule
